// File: rtl/touch_spi_responder.sv
// touch_spi_responder: touch-controller side of the touch SPI link, returning channel samples for captured commands.
module touch_spi_responder #(
  parameter int SAMPLE_W = 12,
  parameter int RESP_W = 16
) (
  input  logic                clk_1MHz,
  input  logic                rst_n,
  input  logic                i_cs,
  input  logic                i_sck,
  input  logic                i_sdi,
  output logic                o_sdo,
  output logic                o_irq,
  input  logic                i_touch,
  input  logic [SAMPLE_W-1:0] x_val,
  input  logic [SAMPLE_W-1:0] y_val,
  input  logic [SAMPLE_W-1:0] z1_val,
  input  logic [SAMPLE_W-1:0] z2_val,
  output logic [7:0]          cmd_out,
  output logic                cmd_valid,
  output logic                cmd_err,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;
  localparam int CW = $clog2(RESP_W + 1);
  state_t state, state_d;
  logic sck_prev, irq_q, rise, fall, last_cmd, last_resp;
  logic [CW-1:0] cnt;
  logic [6:0] cmd_sr;
  logic [7:0] cmd_full;
  logic [SAMPLE_W-1:0] sample;
  logic [RESP_W-1:0] resp, word;
  assign o_irq = i_cs ? irq_q : 1'b1;
  always_comb begin
    rise = i_sck & ~sck_prev & ~i_cs;
    fall = ~i_sck & sck_prev & ~i_cs;
    // the 8th bit is still on i_sdi while the full command is evaluated
    cmd_full = {i_sdi, cmd_sr};
    sample = cmd_full[6:4] == 3'b101 ? x_val :
             cmd_full[6:4] == 3'b001 ? y_val :
             cmd_full[6:4] == 3'b011 ? z1_val :
             cmd_full[6:4] == 3'b100 ? z2_val : '0;
    word = !cmd_full[7] ? '0 :
           cmd_full[3] ? RESP_W'(sample[SAMPLE_W-1 -: 8]) << (RESP_W - 9) :
                         RESP_W'(sample) << (RESP_W - 1 - SAMPLE_W);
    last_cmd = rise && cnt == CW'(7);
    last_resp = fall && cnt == CW'(RESP_W);
    state_d = state;
    case (state)
      IDLE: state_d = i_cs ? IDLE : CMD;
      CMD:  state_d = i_cs ? IDLE : last_cmd ? RESP : CMD;
      RESP: state_d = i_cs ? IDLE : last_resp ? DONE : RESP;
      DONE: state_d = i_cs ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sck_prev <= 1'b0;
      irq_q <= 1'b1;
      o_sdo <= 1'b0;
      cmd_out <= '0;
      cmd_valid <= 1'b0;
      cmd_err <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
      cmd_sr <= '0;
      resp <= '0;
    end else begin
      state <= state_d;
      sck_prev <= i_sck;
      irq_q <= ~i_touch;
      cmd_valid <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          o_sdo <= 1'b0;
          busy <= ~i_cs;
          cnt <= '0;
          cmd_sr <= '0;
        end
        CMD:
          if (i_cs) busy <= 1'b0;
          else if (rise) begin
            cmd_sr <= {i_sdi, cmd_sr[6:1]};
            cnt <= last_cmd ? '0 : cnt + 1'b1;
            if (last_cmd) begin
              cmd_out <= cmd_full;
              cmd_valid <= 1'b1;
              cmd_err <= ~i_sdi;
              resp <= word;
            end
          end
        RESP:
          if (i_cs) begin
            busy <= 1'b0;
            o_sdo <= 1'b0;
          end else if (fall) begin
            o_sdo <= last_resp ? 1'b0 : resp[RESP_W-1];
            resp <= resp << 1;
            cnt <= cnt + 1'b1;
          end
        default: begin
          o_sdo <= 1'b0;
          busy <= ~i_cs;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_touch_spi_responder.sv
// tb_touch_spi_responder: table-driven SPI master with a command scoreboard for touch_spi_responder.
module tb_touch_spi_responder;
  logic clk_1MHz = 1'b0, rst_n = 1'b0, i_cs = 1'b1, i_sck = 1'b0, i_sdi = 1'b0, i_touch = 1'b0;
  logic o_sdo, o_irq, cmd_valid, cmd_err, busy;
  logic [11:0] x_val = 12'hABC, y_val = 12'h123, z1_val = 12'hFFF, z2_val = 12'h456;
  logic [7:0] cmd_out;
  int checks = 0, errors = 0;
  logic [9:0] exp_q[$], obs_q[$];
  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] word;
    logic        err;
  } vec_t;
  vec_t vecs[8];

  touch_spi_responder dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .i_cs(i_cs), .i_sck(i_sck), .i_sdi(i_sdi),
    .o_sdo(o_sdo), .o_irq(o_irq), .i_touch(i_touch), .x_val(x_val), .y_val(y_val),
    .z1_val(z1_val), .z2_val(z2_val), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
    .cmd_err(cmd_err), .busy(busy)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  always @(negedge clk_1MHz)
    if (cmd_valid || cmd_err) obs_q.push_back({cmd_valid, cmd_err, cmd_out});

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1MHz);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic score();
    logic [9:0] e, o;
    chk("pulse_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("cmd_pulse", o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic send_bits(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      i_sdi = c[i];
      i_sck = 1'b0;
      tick(2);
      i_sck = 1'b1;
      tick(2);
    end
  endtask

  task automatic read_word(input bit chg, output logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      i_sck = 1'b0;
      if (chg && i == 3) x_val = 12'hFFF;
      tick(2);
      w[15-i] = o_sdo;
      i_sck = 1'b1;
      tick(2);
    end
    i_sck = 1'b0;
    tick(2);
  endtask

  task automatic xfer(input logic [7:0] c, input bit chg, input logic [15:0] exp_w, input logic exp_err);
    logic [15:0] w;
    exp_q.push_back({1'b1, exp_err, c});
    i_cs = 1'b0;
    tick(2);
    chk("busy_hi", busy, 1'b1);
    send_bits(c, 8);
    chk("irq_cs_low", o_irq, 1'b1);
    read_word(chg, w);
    chk($sformatf("word_%02h", c), w, exp_w);
    chk("sdo_done", o_sdo, 1'b0);
    i_cs = 1'b1;
    tick(1);
    chk("busy_lo", busy, 1'b0);
    score();
  endtask

  initial begin
    vecs[0] = '{8'hD0, 16'h55E0, 1'b0};
    vecs[1] = '{8'h98, 16'h0900, 1'b0};
    vecs[2] = '{8'h50, 16'h0000, 1'b1};
    vecs[3] = '{8'hB0, 16'h7FF8, 1'b0};
    vecs[4] = '{8'hC0, 16'h22B0, 1'b0};
    vecs[5] = '{8'h80, 16'h0000, 1'b0};
    vecs[6] = '{8'hD8, 16'h5580, 1'b0};
    vecs[7] = '{8'hB8, 16'h7F80, 1'b0};
    tick(2);
    chk("rst_sdo", o_sdo, 1'b0);
    chk("rst_irq", o_irq, 1'b1);
    chk("rst_cmd", cmd_out, 8'h00);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick(2);
    foreach (vecs[k]) xfer(vecs[k].cmd, 1'b0, vecs[k].word, vecs[k].err);
    // aborted command: no pulse, cmd_out keeps the last full command
    i_cs = 1'b0;
    tick(2);
    send_bits(8'hD0, 5);
    i_cs = 1'b1;
    i_sck = 1'b0;
    tick(1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cmd", cmd_out, 8'hB8);
    score();
    tick(1);
    xfer(8'hB0, 1'b0, 16'h7FF8, 1'b0);
    x_val = 12'h000;
    xfer(8'hD0, 1'b1, 16'h0000, 1'b0);
    xfer(8'hD0, 1'b0, 16'h7FF8, 1'b0);
    i_touch = 1'b1;
    tick(1);
    chk("irq_touch", o_irq, 1'b0);
    i_cs = 1'b0;
    #1;
    chk("irq_forced", o_irq, 1'b1);
    x_val = 12'hABC;
    exp_q.push_back({2'b10, 8'hD0});
    tick(2);
    send_bits(8'hD0, 8);
    for (int i = 0; i < 2; i++) begin
      i_sck = 1'b0;
      tick(2);
      i_sck = 1'b1;
      tick(2);
    end
    chk("mid_resp_sdo", o_sdo, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sdo", o_sdo, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_state", 32'(dut.state), 32'd0);
    chk("rst_mid_cmd", cmd_out, 8'h00);
    score();
    i_cs = 1'b1;
    i_sck = 1'b0;
    i_touch = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("irq_release", o_irq, 1'b1);
    xfer(8'hD0, 1'b0, 16'h55E0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
